// File: rtl/emu_time_pkg.sv
// Shared types and constants for the emulation time manager: control modes,
// FSM states and the "no constraint" all-ones dt value.
package emu_time_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_STOP_AT = 2'd1,
        MODE_PAUSE   = 2'd2,
        MODE_STEP    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_STOP_WAIT = 2'd1,
        ST_HALT      = 2'd2,
        ST_STEP_ARM  = 2'd3
    } state_e;

    // All-ones value of the given width (up to 64 bits); callers cast to their dt width.
    function automatic logic [63:0] dt_no_constraint(input int unsigned width);
        if (width >= 64)
            return '1;
        else
            return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/emu_dt_min_tree.sv
// Combinational binary-tree unsigned minimum over N_REQ packed slots, plus a
// vector flagging every slot equal to that minimum.
module emu_dt_min_tree
    import emu_time_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DT_WIDTH = 32
) (
    input  logic [N_REQ*DT_WIDTH-1:0] i_req,
    output logic [DT_WIDTH-1:0]       o_min,
    output logic [N_REQ-1:0]          o_tie
);

    localparam int LG = (N_REQ > 1) ? $clog2(N_REQ) : 0;
    localparam int P  = 1 << LG;
    localparam logic [DT_WIDTH-1:0] C_NC = DT_WIDTH'(dt_no_constraint(DT_WIDTH));

    // Heap layout: node 1 is the root, leaves live at P .. 2P-1.
    logic [DT_WIDTH-1:0] w_node [1:2*P-1];

    always_comb begin
        for (int i = 0; i < P; i++) begin
            w_node[P+i] = C_NC;
        end
        for (int i = 0; i < N_REQ; i++) begin
            w_node[P+i] = i_req[i*DT_WIDTH +: DT_WIDTH];
        end
        for (int k = P - 1; k >= 1; k--) begin
            w_node[k] = (w_node[2*k+1] < w_node[2*k]) ? w_node[2*k+1] : w_node[2*k];
        end
        o_min = w_node[1];
        o_tie = '0;
        for (int i = 0; i < N_REQ; i++) begin
            o_tie[i] = (i_req[i*DT_WIDTH +: DT_WIDTH] == o_min);
        end
    end

endmodule

// File: rtl/emu_time_mgr_n.sv
// Emulation time manager: min-of-N dt arbitration, run/stop-at/pause/step control,
// saturating time accumulator and decimated capture strobe.
// Optional request masking is enabled by defining EMU_TIME_MGR_REQ_MASK_EN.
module emu_time_mgr_n
    import emu_time_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DT_WIDTH   = 32,
    parameter int TIME_WIDTH = 64,
    parameter int DEC_WIDTH  = 24
) (
    input  logic                      emu_clk,
    input  logic                      emu_rst,
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
`ifdef EMU_TIME_MGR_REQ_MASK_EN
    input  logic [N_REQ-1:0]          req_mask,
`endif
    input  logic [1:0]                ctrl_mode,
    input  logic [TIME_WIDTH-1:0]     ctrl_data,
    input  logic                      step,
    input  logic [DEC_WIDTH-1:0]      dec_thr,
    output logic [DT_WIDTH-1:0]       emu_dt,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic [N_REQ-1:0]          dt_grant,
    output logic                      emu_dec_cmp,
    output logic                      stopped,
    output logic                      time_ovf,
    output logic [1:0]                o_dbg_state
);

    localparam logic [DT_WIDTH-1:0] C_NC = DT_WIDTH'(dt_no_constraint(DT_WIDTH));

    logic [N_REQ*DT_WIDTH-1:0] w_req_eff;
    logic [N_REQ-1:0]          w_tie;
    logic [N_REQ-1:0]          w_grant_src;
    logic [DT_WIDTH-1:0]       w_min;
    logic [DT_WIDTH-1:0]       w_dt;
    logic [TIME_WIDTH-1:0]     w_remain;
    logic [TIME_WIDTH-1:0]     w_min_ext;
    logic [TIME_WIDTH:0]       w_sum;
    logic [TIME_WIDTH-1:0]     w_time_nxt;
    logic                      w_carry;
    logic                      w_before_stop;
    logic                      w_step_edge;
    mode_e                     w_mode;
    state_e                    r_state;
    state_e                    w_state_nxt;

    logic [TIME_WIDTH-1:0]     r_time;
    logic [DEC_WIDTH-1:0]      r_dec_cnt;
    logic                      r_dec_cmp;
    logic                      r_stopped;
    logic                      r_ovf;
    logic                      r_step_q;

`ifdef EMU_TIME_MGR_REQ_MASK_EN
    // A masked slot looks unconstrained to the tree and can never win a grant.
    always_comb begin
        w_req_eff = dt_req;
        for (int i = 0; i < N_REQ; i++) begin
            if (!req_mask[i])
                w_req_eff[i*DT_WIDTH +: DT_WIDTH] = C_NC;
        end
    end
    assign w_grant_src = w_tie & req_mask;
`else
    assign w_req_eff   = dt_req;
    assign w_grant_src = w_tie;
`endif

    emu_dt_min_tree #(
        .N_REQ    (N_REQ),
        .DT_WIDTH (DT_WIDTH)
    ) u_min_tree (
        .i_req (w_req_eff),
        .o_min (w_min),
        .o_tie (w_tie)
    );

    assign w_mode        = mode_e'(ctrl_mode);
    assign w_step_edge   = step & ~r_step_q;
    assign w_before_stop = (r_time < ctrl_data);
    assign w_remain      = ctrl_data - r_time;
    assign w_min_ext     = TIME_WIDTH'(w_min);

    always_comb begin
        w_dt = '0;
        if (!r_ovf) begin
            case (r_state)
                ST_RUN, ST_STEP_ARM: w_dt = w_min;
                ST_STOP_WAIT: begin
                    if (w_before_stop)
                        w_dt = (w_remain < w_min_ext) ? DT_WIDTH'(w_remain) : w_min;
                end
                default: w_dt = '0;
            endcase
        end
    end

    assign w_sum      = {1'b0, r_time} + {{(TIME_WIDTH + 1 - DT_WIDTH){1'b0}}, w_dt};
    assign w_carry    = w_sum[TIME_WIDTH];
    assign w_time_nxt = w_carry ? {TIME_WIDTH{1'b1}} : w_sum[TIME_WIDTH-1:0];

    // Next state looks at the post-advance time so a stop lands exactly on ctrl_data.
    always_comb begin
        w_state_nxt = r_state;
        case (w_mode)
            MODE_RUN:     w_state_nxt = ST_RUN;
            MODE_STOP_AT: w_state_nxt = (w_time_nxt < ctrl_data) ? ST_STOP_WAIT : ST_HALT;
            MODE_PAUSE:   w_state_nxt = ST_HALT;
            MODE_STEP:    w_state_nxt = (r_state != ST_STEP_ARM && w_step_edge) ? ST_STEP_ARM
                                                                                : ST_HALT;
        endcase
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            r_time    <= '0;
            r_dec_cnt <= '0;
            r_dec_cmp <= 1'b0;
            r_stopped <= 1'b0;
            r_ovf     <= 1'b0;
            r_step_q  <= 1'b0;
        end else begin
            r_step_q  <= step;
            r_time    <= w_time_nxt;
            r_stopped <= (w_state_nxt == ST_HALT);
            if (w_carry)
                r_ovf <= 1'b1;
            r_dec_cmp <= 1'b0;
            if (w_dt != '0) begin
                if (r_dec_cnt == dec_thr) begin
                    r_dec_cnt <= '0;
                    r_dec_cmp <= 1'b1;
                end else begin
                    r_dec_cnt <= r_dec_cnt + 1'b1;
                end
            end
        end
    end

    assign emu_dt      = w_dt;
    assign emu_time    = r_time;
    assign dt_grant    = (w_dt != '0) ? w_grant_src : '0;
    assign emu_dec_cmp = r_dec_cmp;
    assign stopped     = r_stopped;
    assign time_ovf    = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_emu_time_mgr_n.sv
// Directed bench for emu_time_mgr_n: default-width instance plus a 34-bit time
// instance for saturation; expectations flow through a scoreboard queue.
module tb_emu_time_mgr_n;

    logic         clk;
    logic         rst;
    logic [127:0] dt_req;
    logic [1:0]   ctrl_mode;
    logic [63:0]  ctrl_data;
    logic         step;
    logic [23:0]  dec_thr;
    logic [31:0]  emu_dt;
    logic [63:0]  emu_time;
    logic [3:0]   dt_grant;
    logic         dec_cmp;
    logic         stopped;
    logic         ovf;
    logic [1:0]   dbg;

    logic         s_rst;
    logic [127:0] s_dt_req;
    logic [33:0]  s_ctrl_data;
    logic [23:0]  s_dec_thr;
    logic [31:0]  s_emu_dt;
    logic [33:0]  s_emu_time;
    logic [3:0]   s_grant;
    logic         s_dec;
    logic         s_stopped;
    logic         s_ovf;
    logic [1:0]   s_dbg;
    logic [3:0]   req_mask;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        sel;
        logic [31:0] dt;
        logic [3:0]  grant;
        logic [63:0] tm;
        logic        stp;
        logic        dec;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    emu_time_mgr_n dut (
        .emu_clk     (clk),
        .emu_rst     (rst),
        .dt_req      (dt_req),
`ifdef EMU_TIME_MGR_REQ_MASK_EN
        .req_mask    (req_mask),
`endif
        .ctrl_mode   (ctrl_mode),
        .ctrl_data   (ctrl_data),
        .step        (step),
        .dec_thr     (dec_thr),
        .emu_dt      (emu_dt),
        .emu_time    (emu_time),
        .dt_grant    (dt_grant),
        .emu_dec_cmp (dec_cmp),
        .stopped     (stopped),
        .time_ovf    (ovf),
        .o_dbg_state (dbg)
    );

    emu_time_mgr_n #(.TIME_WIDTH(34)) dut_s (
        .emu_clk     (clk),
        .emu_rst     (s_rst),
        .dt_req      (s_dt_req),
`ifdef EMU_TIME_MGR_REQ_MASK_EN
        .req_mask    (4'hF),
`endif
        .ctrl_mode   (2'd0),
        .ctrl_data   (s_ctrl_data),
        .step        (1'b0),
        .dec_thr     (s_dec_thr),
        .emu_dt      (s_emu_dt),
        .emu_time    (s_emu_time),
        .dt_grant    (s_grant),
        .emu_dec_cmp (s_dec),
        .stopped     (s_stopped),
        .time_ovf    (s_ovf),
        .o_dbg_state (s_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: comb outputs checked mid-cycle, registered ones after the edge.
    task automatic cyc(input logic sel, input logic [31:0] dt, input logic [3:0] gr,
                       input logic [63:0] tm, input logic stp, input logic dec, input logic ov);
        exp_t e;
        exp_t got;
        e = '{sel, dt, gr, tm, stp, dec, ov};
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        if (!got.sel) begin
            chk("emu_dt", 64'(emu_dt), 64'(got.dt));
            chk("dt_grant", 64'(dt_grant), 64'(got.grant));
        end else begin
            chk("s_emu_dt", 64'(s_emu_dt), 64'(got.dt));
            chk("s_dt_grant", 64'(s_grant), 64'(got.grant));
        end
        @(posedge clk);
        #1;
        if (!got.sel) begin
            chk("emu_time", emu_time, got.tm);
            chk("stopped", 64'(stopped), 64'(got.stp));
            chk("emu_dec_cmp", 64'(dec_cmp), 64'(got.dec));
            chk("time_ovf", 64'(ovf), 64'(got.ovf));
        end else begin
            chk("s_emu_time", 64'(s_emu_time), got.tm);
            chk("s_stopped", 64'(s_stopped), 64'(got.stp));
            chk("s_emu_dec_cmp", 64'(s_dec), 64'(got.dec));
            chk("s_time_ovf", 64'(s_ovf), 64'(got.ovf));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        s_rst       = 1'b1;
        dt_req      = '1;
        ctrl_mode   = 2'd0;
        ctrl_data   = 64'd0;
        step        = 1'b0;
        dec_thr     = 24'd1000;
        req_mask    = 4'hF;
        s_dt_req    = {4{32'h8000_0000}};
        s_ctrl_data = 34'd0;
        s_dec_thr   = 24'hFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_time", emu_time, 64'd0);
        chk("rst_stopped", 64'(stopped), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_dec", 64'(dec_cmp), 64'd0);
        chk("rst_state", 64'(dbg), 64'd0);
        rst = 1'b0;

        // RUN: tie between slots 1 and 2
        dt_req = {32'd100, 32'd40, 32'd40, 32'hFFFF_FFFF};
        cyc(1'b0, 32'd40, 4'b0110, 64'd40, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd40, 4'b0110, 64'd80, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd40, 4'b0110, 64'd120, 1'b0, 1'b0, 1'b0);
        do_reset();
        chk("midrun_rst_time", emu_time, 64'd0);

        // STOP_AT 100 with 30-steps, then raise the stop time to 150
        ctrl_mode = 2'd1;
        ctrl_data = 64'd100;
        dt_req    = {4{32'd30}};
        cyc(1'b0, 32'd30, 4'hF, 64'd30, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd30, 4'hF, 64'd60, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd30, 4'hF, 64'd90, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd10, 4'hF, 64'd100, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 4'h0, 64'd100, 1'b1, 1'b0, 1'b0);
        chk("halt_state", 64'(dbg), 64'd2);
        ctrl_data = 64'd150;
        cyc(1'b0, 32'd0, 4'h0, 64'd100, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd30, 4'hF, 64'd130, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd20, 4'hF, 64'd150, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 4'h0, 64'd150, 1'b1, 1'b0, 1'b0);

        // STEP: two pulses five cycles apart, step held high does not re-arm
        do_reset();
        ctrl_mode = 2'd3;
        dt_req    = '0;
        cyc(1'b0, 32'd0, 4'h0, 64'd0, 1'b1, 1'b0, 1'b0);
        dt_req = {4{32'd7}};
        cyc(1'b0, 32'd0, 4'h0, 64'd0, 1'b1, 1'b0, 1'b0);
        step = 1'b1;
        cyc(1'b0, 32'd0, 4'h0, 64'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd7, 4'hF, 64'd7, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 4'h0, 64'd7, 1'b1, 1'b0, 1'b0);
        step = 1'b0;
        cyc(1'b0, 32'd0, 4'h0, 64'd7, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 4'h0, 64'd7, 1'b1, 1'b0, 1'b0);
        step = 1'b1;
        cyc(1'b0, 32'd0, 4'h0, 64'd7, 1'b0, 1'b0, 1'b0);
        step = 1'b0;
        cyc(1'b0, 32'd7, 4'hF, 64'd14, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 4'h0, 64'd14, 1'b1, 1'b0, 1'b0);

        // Decimation with dec_thr = 2, zero-request gap, then dec_thr = 0
        ctrl_mode = 2'd0;
        dec_thr   = 24'd2;
        dt_req    = {4{32'd1}};
        do_reset();
        cyc(1'b0, 32'd1, 4'hF, 64'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd1, 4'hF, 64'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd1, 4'hF, 64'd3, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'd1, 4'hF, 64'd4, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd1, 4'hF, 64'd5, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd1, 4'hF, 64'd6, 1'b0, 1'b1, 1'b0);
        dt_req = {32'd1, 32'd0, 32'd1, 32'd1};
        cyc(1'b0, 32'd0, 4'h0, 64'd6, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 4'h0, 64'd6, 1'b0, 1'b0, 1'b0);
        dt_req = {4{32'd1}};
        cyc(1'b0, 32'd1, 4'hF, 64'd7, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd1, 4'hF, 64'd8, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd1, 4'hF, 64'd9, 1'b0, 1'b1, 1'b0);
        dec_thr = 24'd0;
        cyc(1'b0, 32'd1, 4'hF, 64'd10, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'd1, 4'hF, 64'd11, 1'b0, 1'b1, 1'b0);

        // Single winner, then every slot unconstrained
        dt_req = {32'd9, 32'd3, 32'd8, 32'd5};
        cyc(1'b0, 32'd3, 4'b0100, 64'd14, 1'b0, 1'b1, 1'b0);
        dt_req = '1;
        cyc(1'b0, 32'hFFFF_FFFF, 4'hF, 64'h1_0000_000D, 1'b0, 1'b1, 1'b0);
`ifdef EMU_TIME_MGR_REQ_MASK_EN
        req_mask = 4'b1110;
        dt_req   = {32'd50, 32'd50, 32'd50, 32'd1};
        cyc(1'b0, 32'd50, 4'b1110, 64'h1_0000_003F, 1'b0, 1'b1, 1'b0);
        req_mask = 4'hF;
`endif

        // Saturation on the 34-bit instance, then a reset out of overflow
        s_rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b1, 32'h8000_0000, 4'hF, 64'(k) << 31, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, 32'h8000_0000, 4'hF, 64'h3_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'd0, 4'h0, 64'h3_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
        s_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("s_rst_time", 64'(s_emu_time), 64'd0);
        chk("s_rst_ovf", 64'(s_ovf), 64'd0);
        chk("s_rst_stopped", 64'(s_stopped), 64'd0);
        chk("s_rst_state", 64'(s_dbg), 64'd0);
        s_rst = 1'b0;
        cyc(1'b1, 32'h8000_0000, 4'hF, 64'h8000_0000, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/emu_time_mgr_n.md
Name: emu_time_mgr_n

Overview:
- Next-generation emulation time manager for the generated emulation top.
- Collects N_REQ timestep requests from oscillators and stall sources and issues a single emu_dt: the minimum request, further clamped by the control mode.
- Accumulates emu_time, emits grant flags to the winning requesters, and drives the decimated trace-capture strobe.
- Adds run / stop-at-time / pause / single-step control that the previous fixed two-request manager lacked.

Parameters:
- N_REQ, 4, number of dt requesters (1..16).
- DT_WIDTH, 32, width of each dt request and of emu_dt.
- TIME_WIDTH, 64, width of emu_time and ctrl_data.
- DEC_WIDTH, 24, width of the decimation threshold.

Ports:
- emu_clk  in  1  emulation clock.
- emu_rst  in  1  synchronous active-high reset.
- dt_req  in  N_REQ*DT_WIDTH  flattened requests; slot i = bits [i*DT_WIDTH +: DT_WIDTH]; all-ones means "no constraint".
- ctrl_mode  in  2  0 = RUN, 1 = STOP_AT, 2 = PAUSE, 3 = STEP.
- ctrl_data  in  TIME_WIDTH  stop time for STOP_AT.
- step  in  1  single-step request, edge-detected internally.
- dec_thr  in  DEC_WIDTH  number of advances between capture strobes, minus one.
- emu_dt  out  DT_WIDTH  timestep applied this cycle (combinational).
- emu_time  out  TIME_WIDTH  accumulated emulation time (registered).
- dt_grant  out  N_REQ  bit i high when slot i equals the minimum and emu_dt != 0 (combinational).
- emu_dec_cmp  out  1  one-cycle capture strobe (registered).
- stopped  out  1  high while no advance is permitted (registered).
- time_ovf  out  1  sticky saturation flag (registered).

Behaviour:
- Reset (sync, active-high), on the next emu_clk edge:
  - emu_time = 0, decimation counter = 0, emu_dec_cmp = 0, stopped = 0, time_ovf = 0, step edge register = 0, FSM = RUN.
- Reset applied mid-step or mid-stop discards all pending state.
- Minimum:
  - m = unsigned minimum over all slots.
  - Ties: every equal slot receives a grant.
  - All slots all-ones: m = 2^DT_WIDTH-1.
- FSM states: RUN, STOP_WAIT, HALT, STEP_ARM.
  - RUN: ctrl_mode=0; emu_dt = m.
  - STOP_WAIT: ctrl_mode=1 and emu_time < ctrl_data.
    - emu_dt = min(m, ctrl_data - emu_time); landing exactly on ctrl_data is mandatory.
    - Moves to HALT when emu_time + emu_dt == ctrl_data.
  - HALT: emu_dt = 0, stopped = 1. Entered when:
    - ctrl_mode=2; or
    - ctrl_mode=1 with emu_time >= ctrl_data; or
    - ctrl_mode=3 and no step edge pending.
  - STEP_ARM: entered on a rising edge of step in mode 3.
    - Exactly one cycle with emu_dt = m, then back to HALT.
    - A step edge arriving during STEP_ARM is ignored.
  - Mode changes take effect in the cycle after ctrl_mode is sampled (one-cycle latency). Leaving HALT to RUN clears stopped on that edge.
  - Writing a new ctrl_data greater than emu_time while in mode 1 returns HALT to STOP_WAIT.
- Time update: emu_time <= emu_time + emu_dt, computed in TIME_WIDTH+1 bits.
  - On carry-out: emu_time saturates at all-ones, time_ovf is set, and emu_dt is forced to 0 from then on until reset.
- Decimation: the counter increments only on cycles with emu_dt != 0.
  - When counter == dec_thr: emu_dec_cmp = 1 on the next cycle and counter <= 0.
  - dec_thr = 0 gives a strobe after every advance.
  - A dec_thr change below the current count takes effect at the next wrap: counter compares with ==, runs to 2^DEC_WIDTH-1, then wraps to 0.
- Zero requests: if m = 0, emu_dt = 0, all dt_grant = 0, no advance, no counter increment.

Optional Feature:
- Macro: EMU_TIME_MGR_REQ_MASK_EN.
- Defined: adds input req_mask [N_REQ]; a slot whose mask bit is 0 is treated as all-ones and never granted. Mask is sampled combinationally.
- Undefined: no port; all slots participate.

Decomposition:
- Package emu_time_pkg:
  - mode enum (RUN, STOP_AT, PAUSE, STEP) and FSM state enum.
  - DT_NO_CONSTRAINT all-ones constant function of DT_WIDTH.
- Sub-module emu_dt_min_tree: parametrised combinational binary-tree minimum. Outputs min value and tie vector.

Test Plan:
- RUN with dt_req = {100, 40, 40, all-ones} -> emu_dt = 40, dt_grant = 4'b0110, emu_time = 40, 80, 120 on successive cycles.
- STOP_AT with ctrl_data = 100, all requests 30 -> emu_dt sequence 30, 30, 30, 10; emu_time = 100, then stopped = 1, emu_dt = 0, dt_grant = 0.
- STEP mode, m = 7, two step pulses 5 cycles apart -> exactly two advances, emu_time = 14, stopped high between pulses.
- dec_thr = 2, RUN with m = 1 -> emu_dec_cmp high every third advance (after emu_time = 3, 6, 9); a request of 0 inserted for 2 cycles delays the strobe by 2 cycles.
- emu_time preset near max via repeated dt = 2^31, TIME_WIDTH = 34 -> saturation to all-ones, time_ovf = 1, emu_dt = 0; emu_rst mid-run clears everything in one cycle.
- With EMU_TIME_MGR_REQ_MASK_EN, req_mask = 4'b1110, dt_req slot0 = 1, others 50 -> emu_dt = 50, dt_grant[0] = 0.
